// File: rtl/path_count_sequencer_if.sv
// Decoder-to-sequencer link: edge stream and start strobe in, solver status and result out.
interface path_count_sequencer_if #(
  parameter int unsigned NODE_WIDTH  = 15,
  parameter int unsigned COUNT_WIDTH = 64
);
  logic                   edge_valid;
  logic [NODE_WIDTH-1:0]  src_node;
  logic [NODE_WIDTH-1:0]  dst_node;
  logic                   decoding_done;
  logic                   busy;
  logic                   done;
  logic [COUNT_WIDTH-1:0] path_count;
  logic                   overflow;
  logic                   error;

  // Decoder side.
  modport master (
    output edge_valid, src_node, dst_node, decoding_done,
    input  busy, done, path_count, overflow, error
  );

  // Sequencer side.
  modport slave (
    input  edge_valid, src_node, dst_node, decoding_done,
    output busy, done, path_count, overflow, error
  );
endinterface

// File: rtl/path_count_sequencer.sv
// Stores decoded edges, then counts START_NODE -> TARGET_NODE paths with a level-by-level sweep
// over two ping-pong node-count banks. One edge is processed every 3 cycles in the sweep.
module path_count_sequencer #(
  parameter int unsigned           NODE_WIDTH      = 15,
  parameter int unsigned           EDGE_ADDR_WIDTH = 11,
  parameter int unsigned           COUNT_WIDTH     = 64,
  parameter logic [NODE_WIDTH-1:0] START_NODE      = 15'h51D8,
  parameter logic [NODE_WIDTH-1:0] TARGET_NODE     = 15'h4E8E,
  parameter int unsigned           MAX_ITER        = 1024
) (
  input logic                   clk,
  input logic                   reset_n,
  path_count_sequencer_if.slave bus
);

  localparam int unsigned EW    = EDGE_ADDR_WIDTH;
  localparam int unsigned IterW = $clog2(MAX_ITER + 1);
  localparam logic [EW:0] Capacity = {1'b1, {EW{1'b0}}};

  typedef enum logic [3:0] {
    StLoad, StInit, StStart, StClear, StErd, StCrd, StWr, StCheck, StDone
  } state_e;

  state_e state_q, state_d;

  // Edge RAM ({src, dst}) and the two count banks; none of them is reset.
  logic [2*NODE_WIDTH-1:0]  edge_mem  [2**EDGE_ADDR_WIDTH];
  logic [COUNT_WIDTH-1:0]   bank0_mem [2**NODE_WIDTH];
  logic [COUNT_WIDTH-1:0]   bank1_mem [2**NODE_WIDTH];

  logic [EW:0]              n_edges_q;
  logic [EW-1:0]            idx_q;
  logic                     ph_q;      // 0: src half of an edge, 1: dst half
  logic [2*NODE_WIDTH-1:0]  edge_q;
  logic                     cur_sel_q; // 0: cur=B0/next=B1, 1: cur=B1/next=B0
  logic [IterW-1:0]         iter_q;
  logic [COUNT_WIDTH-1:0]   total_q;
  logic                     active_q;
  logic                     overflow_q;
  logic                     error_q;

  logic [COUNT_WIDTH-1:0]   b0_rdata_q, b1_rdata_q;
  logic                     b0_we, b1_we;
  logic [NODE_WIDTH-1:0]    b0_waddr, b1_waddr, b0_raddr, b1_raddr;
  logic [COUNT_WIDTH-1:0]   b0_wdata, b1_wdata;

  logic                     edge_store;
  logic                     load_empty;
  logic                     last_edge;
  logic                     at_max_iter;
  logic [2*NODE_WIDTH-1:0]  edge_rd;
  logic [NODE_WIDTH-1:0]    rd_src, rd_dst, q_src, q_dst, walk_node;
  logic [COUNT_WIDTH-1:0]   cur_val, next_val;
  logic [COUNT_WIDTH:0]     bank_sum, total_sum;
  logic                     hits_target;

  assign edge_store  = (state_q == StLoad) && bus.edge_valid && (n_edges_q != Capacity);
  assign load_empty  = (n_edges_q == '0) && !edge_store;
  assign last_edge   = (({1'b0, idx_q} + (EW + 1)'(1)) == n_edges_q);
  assign at_max_iter = (iter_q == IterW'(MAX_ITER - 1));

  assign edge_rd   = edge_mem[idx_q];
  assign rd_src    = edge_rd[2*NODE_WIDTH-1:NODE_WIDTH];
  assign rd_dst    = edge_rd[NODE_WIDTH-1:0];
  assign q_src     = edge_q[2*NODE_WIDTH-1:NODE_WIDTH];
  assign q_dst     = edge_q[NODE_WIDTH-1:0];
  assign walk_node = ph_q ? rd_dst : rd_src;

  assign cur_val     = cur_sel_q ? b1_rdata_q : b0_rdata_q;
  assign next_val    = cur_sel_q ? b0_rdata_q : b1_rdata_q;
  assign bank_sum    = {1'b0, next_val} + {1'b0, cur_val};
  assign total_sum   = {1'b0, total_q} + {1'b0, cur_val};
  assign hits_target = (q_dst == TARGET_NODE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StLoad;
    else          state_q <= state_d;
  end

  // Next-state: phase sequencing over the edge list.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (bus.decoding_done) state_d = load_empty ? StDone : StInit;
      StInit:  if (ph_q && last_edge) state_d = StStart;
      StStart: state_d = StClear;
      StClear: if (ph_q && last_edge) state_d = StErd;
      StErd:   state_d = StCrd;
      StCrd:   state_d = StWr;
      StWr:    state_d = last_edge ? StCheck : StErd;
      StCheck: state_d = (!active_q || at_max_iter) ? StDone : StClear;
      StDone:  state_d = StDone;
      default: state_d = StLoad;
    endcase
  end

  // Outputs and bank port controls.
  always_comb begin
    b0_we    = 1'b0;
    b1_we    = 1'b0;
    b0_waddr = '0;
    b1_waddr = '0;
    b0_wdata = '0;
    b1_wdata = '0;
    // cur bank reads src, next bank reads dst; only the values read in C_RD are consumed.
    b0_raddr = cur_sel_q ? q_dst : q_src;
    b1_raddr = cur_sel_q ? q_src : q_dst;
    unique case (state_q)
      StInit: begin
        b0_we    = 1'b1;
        b1_we    = 1'b1;
        b0_waddr = walk_node;
        b1_waddr = walk_node;
      end
      StStart: begin
        b0_we    = 1'b1;
        b0_waddr = START_NODE;
        b0_wdata = COUNT_WIDTH'(1);
      end
      StClear: begin
        b0_we    = cur_sel_q;
        b1_we    = !cur_sel_q;
        b0_waddr = walk_node;
        b1_waddr = walk_node;
      end
      StWr: begin
        b0_we    = cur_sel_q;
        b1_we    = !cur_sel_q;
        b0_waddr = q_dst;
        b1_waddr = q_dst;
        b0_wdata = bank_sum[COUNT_WIDTH-1:0];
        b1_wdata = bank_sum[COUNT_WIDTH-1:0];
      end
      default: ;
    endcase
    bus.busy       = (state_q != StLoad) && (state_q != StDone);
    bus.done       = (state_q == StDone);
    bus.path_count = (state_q == StDone) ? total_q : '0;
    bus.overflow   = overflow_q;
    bus.error      = error_q;
  end

  // Datapath registers: edge counter, walk index, sweep accumulators and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_edges_q  <= '0;
      idx_q      <= '0;
      ph_q       <= 1'b0;
      edge_q     <= '0;
      cur_sel_q  <= 1'b0;
      iter_q     <= '0;
      total_q    <= '0;
      active_q   <= 1'b0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      ph_q <= ((state_q == StInit) || (state_q == StClear)) ? !ph_q : 1'b0;
      unique case (state_q)
        StLoad: begin
          if (edge_store) n_edges_q <= n_edges_q + (EW + 1)'(1);
          else if (bus.edge_valid) error_q <= 1'b1;
        end
        StInit, StClear: begin
          if (ph_q) idx_q <= last_edge ? '0 : idx_q + EW'(1);
        end
        StStart: begin
          cur_sel_q <= 1'b0;
          total_q   <= '0;
          iter_q    <= '0;
          active_q  <= 1'b0;
        end
        StErd: edge_q <= edge_rd;
        StWr: begin
          idx_q <= last_edge ? '0 : idx_q + EW'(1);
          if (cur_val != '0) active_q <= 1'b1;
          if (bank_sum[COUNT_WIDTH]) overflow_q <= 1'b1;
          if (hits_target) begin
            total_q <= total_sum[COUNT_WIDTH-1:0];
            if (total_sum[COUNT_WIDTH]) overflow_q <= 1'b1;
          end
        end
        StCheck: begin
          if (active_q && at_max_iter) begin
            error_q <= 1'b1;
          end else if (active_q) begin
            cur_sel_q <= !cur_sel_q;
            iter_q    <= iter_q + IterW'(1);
            active_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Edge RAM write port.
  always_ff @(posedge clk) begin
    if (edge_store) edge_mem[n_edges_q[EW-1:0]] <= {bus.src_node, bus.dst_node};
  end

  // Count bank B0: one write, one registered read per cycle.
  always_ff @(posedge clk) begin
    if (b0_we) bank0_mem[b0_waddr] <= b0_wdata;
    b0_rdata_q <= bank0_mem[b0_raddr];
  end

  // Count bank B1: one write, one registered read per cycle.
  always_ff @(posedge clk) begin
    if (b1_we) bank1_mem[b1_waddr] <= b1_wdata;
    b1_rdata_q <= bank1_mem[b1_raddr];
  end

endmodule

// File: tb/tb_path_count_sequencer.sv
// Directed bench: three sequencer instances (default, 4-edge capacity, 2-bit counts) share one
// stimulus driver; sel picks which instance sees the inputs and whose outputs are observed.
module tb_path_count_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ev = 1'b0;
  logic        dd = 1'b0;
  logic [14:0] sn = '0;
  logic [14:0] dn = '0;
  int          sel = 0;

  logic        o_busy, o_done, o_ovf, o_err;
  logic [63:0] o_path;

  int n_checks = 0;
  int n_pass   = 0;

  path_count_sequencer_if #(.NODE_WIDTH(15), .COUNT_WIDTH(64)) bus_main ();
  path_count_sequencer_if #(.NODE_WIDTH(15), .COUNT_WIDTH(64)) bus_cap ();
  path_count_sequencer_if #(.NODE_WIDTH(15), .COUNT_WIDTH(2))  bus_ovf ();

  assign bus_main.edge_valid    = ev && (sel == 0);
  assign bus_main.decoding_done = dd && (sel == 0);
  assign bus_main.src_node      = sn;
  assign bus_main.dst_node      = dn;
  assign bus_cap.edge_valid     = ev && (sel == 1);
  assign bus_cap.decoding_done  = dd && (sel == 1);
  assign bus_cap.src_node       = sn;
  assign bus_cap.dst_node       = dn;
  assign bus_ovf.edge_valid     = ev && (sel == 2);
  assign bus_ovf.decoding_done  = dd && (sel == 2);
  assign bus_ovf.src_node       = sn;
  assign bus_ovf.dst_node       = dn;

  always_comb begin
    case (sel)
      1: begin
        o_busy = bus_cap.busy; o_done = bus_cap.done; o_path = bus_cap.path_count;
        o_ovf  = bus_cap.overflow; o_err = bus_cap.error;
      end
      2: begin
        o_busy = bus_ovf.busy; o_done = bus_ovf.done; o_path = 64'(bus_ovf.path_count);
        o_ovf  = bus_ovf.overflow; o_err = bus_ovf.error;
      end
      default: begin
        o_busy = bus_main.busy; o_done = bus_main.done; o_path = bus_main.path_count;
        o_ovf  = bus_main.overflow; o_err = bus_main.error;
      end
    endcase
  end

  path_count_sequencer u_main (.clk(clk), .reset_n(rst_n), .bus(bus_main.slave));
  path_count_sequencer #(.EDGE_ADDR_WIDTH(2)) u_cap (.clk(clk), .reset_n(rst_n), .bus(bus_cap.slave));
  path_count_sequencer #(.COUNT_WIDTH(2)) u_ovf (.clk(clk), .reset_n(rst_n), .bus(bus_ovf.slave));

  always #5 clk = ~clk;

  string puz_s [16] = '{"aaa", "you", "you", "bbb", "bbb", "ccc", "ccc", "ccc",
                        "ddd", "eee", "fff", "ggg", "hhh", "hhh", "hhh", "iii"};
  string puz_d [16] = '{"hhh", "bbb", "ccc", "ddd", "eee", "ddd", "eee", "fff",
                        "ggg", "out", "out", "out", "ccc", "fff", "iii", "out"};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // 3 letters, 5 bits each, first letter in the low bits, 'a' = 0.
  function automatic logic [14:0] nid(input string s);
    logic [4:0] c0, c1, c2;
    c0 = 5'(s[0] - 8'd97);
    c1 = 5'(s[1] - 8'd97);
    c2 = 5'(s[2] - 8'd97);
    return {c2, c1, c0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_edge(input string s, input string d);
    ev = 1'b1;
    sn = nid(s);
    dn = nid(d);
    @(negedge clk);
    ev = 1'b0;
  endtask

  task automatic load_puzzle();
    for (int i = 0; i < 16; i++) send_edge(puz_s[i], puz_d[i]);
  endtask

  // Pulses decoding_done and waits for done. span is the inclusive cycle count from the
  // decoding_done cycle through the first cycle with done high.
  task automatic finish_decode(output int span, output logic busy_next);
    int edges;
    dd = 1'b1;
    @(negedge clk);
    dd = 1'b0;
    ev = 1'b0;
    busy_next = o_busy;
    edges = 0;
    while (!o_done && edges < 5000) begin
      @(negedge clk);
      edges++;
    end
    check_eq("done_reached", 64'(o_done), 64'd1);
    span = edges + 2;
  endtask

  initial begin
    int   span;
    logic bn;

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(o_busy), 0);
    check_eq("rst_done", 64'(o_done), 0);
    check_eq("rst_path", o_path, 0);
    check_eq("rst_ovf", 64'(o_ovf), 0);
    check_eq("rst_err", 64'(o_err), 0);
    rst_n = 1'b1;

    // Puzzle: E=16, K=5 -> 1 + 33 + 5*81 + 1 = 440.
    sel = 0;
    @(negedge clk);
    load_puzzle();
    check_eq("puz_busy_load", 64'(o_busy), 0);
    finish_decode(span, bn);
    check_eq("puz_busy_rise", 64'(bn), 1);
    check_eq("puz_path", o_path, 5);
    check_eq("puz_err", 64'(o_err), 0);
    check_eq("puz_ovf", 64'(o_ovf), 0);
    check_eq("puz_busy_done", 64'(o_busy), 0);
    check_eq("puz_latency", 64'(span), 440);
    send_edge("you", "out");
    repeat (3) @(negedge clk);
    check_eq("puz_hold", o_path, 5);

    // Single edge arriving in the same cycle as decoding_done: E=1, K=2 -> 1+3+12+1 = 17.
    do_reset();
    ev = 1'b1;
    sn = nid("you");
    dn = nid("out");
    finish_decode(span, bn);
    check_eq("one_path", o_path, 1);
    check_eq("one_latency", 64'(span), 17);

    // Adjacent edges into the same dst.
    do_reset();
    send_edge("you", "aaa");
    send_edge("you", "bbb");
    send_edge("aaa", "out");
    send_edge("bbb", "out");
    finish_decode(span, bn);
    check_eq("b2b_path", o_path, 2);
    check_eq("b2b_err", 64'(o_err), 0);

    // Edges exist but none leave the start node.
    do_reset();
    send_edge("aaa", "out");
    send_edge("bbb", "out");
    finish_decode(span, bn);
    check_eq("nop_path", o_path, 0);
    check_eq("nop_done", 64'(o_done), 1);
    check_eq("nop_err", 64'(o_err), 0);

    // No edges at all.
    do_reset();
    finish_decode(span, bn);
    check_eq("empty_path", o_path, 0);
    check_eq("empty_span", 64'(span), 2);

    // Capacity 4: fifth edge dropped, error set, first four kept.
    do_reset();
    sel = 1;
    send_edge("you", "out");
    send_edge("aaa", "bbb");
    send_edge("ccc", "ddd");
    send_edge("eee", "fff");
    send_edge("ggg", "hhh");
    check_eq("cap_err_load", 64'(o_err), 1);
    finish_decode(span, bn);
    check_eq("cap_path", o_path, 1);
    check_eq("cap_err", 64'(o_err), 1);

    // 2-bit counts: four parallel paths wrap to 0.
    do_reset();
    sel = 2;
    send_edge("you", "xaa");
    send_edge("you", "xbb");
    send_edge("you", "xcc");
    send_edge("you", "xdd");
    send_edge("xaa", "out");
    send_edge("xbb", "out");
    send_edge("xcc", "out");
    send_edge("xdd", "out");
    finish_decode(span, bn);
    check_eq("ovf_path", o_path, 0);
    check_eq("ovf_flag", 64'(o_ovf), 1);

    // Reset in the first sweep (INIT 33 + CLEAR 32 cycles precede it), then reload.
    do_reset();
    sel = 0;
    load_puzzle();
    dd = 1'b1;
    @(negedge clk);
    dd = 1'b0;
    repeat (80) @(negedge clk);
    check_eq("mid_busy", 64'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 64'(o_busy), 0);
    check_eq("mid_rst_done", 64'(o_done), 0);
    check_eq("mid_rst_path", o_path, 0);
    check_eq("mid_rst_err", 64'(o_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_puzzle();
    finish_decode(span, bn);
    check_eq("mid_reload_path", o_path, 5);
    check_eq("mid_reload_latency", 64'(span), 440);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
